cnn_mac_pipe_dsp: RTL and testbench
===================================

CNN_MAC_PIPE_DSP -- requirements
Module: cnn_mac_pipe_dsp

Interface
REQ-001 Parameters, one per line (name, default, meaning), SHALL be:
- DIN0_WIDTH, 14: signed width of din0.
- DIN1_WIDTH, 6: signed width of din1.
- ACC_WIDTH, 24: signed accumulator width; SHALL be >= DIN0_WIDTH+DIN1_WIDTH.
- DOUT_WIDTH, 16: signed result width; SHALL be <= ACC_WIDTH.
- OUT_SHIFT, 0: arithmetic right shift applied to the result; SHALL be 0..ACC_WIDTH-1.
REQ-002 Ports, one per line (name, direction, width, meaning), SHALL be:
- ap_clk, in, 1: single clock; all state on its rising edge.
- ap_rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: block accepts the sample this cycle.
- din0, in, DIN0_WIDTH: signed operand a.
- din1, in, DIN1_WIDTH: signed operand b.
- in_first, in, 1: sample starts a new accumulation.
- in_last, in, 1: sample ends the accumulation and emits a result.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- dout, out, DOUT_WIDTH: signed rounded, saturated result.
- out_sat, out, 1: result saturated or accumulator overflowed.

Function
REQ-003 Global enable en = !out_valid || out_ready; in_ready SHALL equal en combinationally; the sample is accepted when in_valid && in_ready.
REQ-004 Stage 1 (when en): register din0, din1, in_first, in_last; v1 <= in_valid.
REQ-005 Stage 2 (when en): p <= signed din0_r*din1_r, full DIN0_WIDTH+DIN1_WIDTH bits; v2, first2, last2 advance from stage 1.
REQ-006 Stage 3 (when en && v2): acc_next = first2 ? sext(p) : acc + sext(p).
- On signed overflow, acc_next SHALL saturate to +/-(2^(ACC_WIDTH-1)) limits and the sticky ovf flag SHALL be set.
- first2 SHALL clear ovf before the add.
REQ-007 No state SHALL change when en=0 (full stall); bubbles (v2=0) SHALL leave acc and ovf unchanged.
REQ-008 Result generation when en && v2 && last2:
- r = (acc_next + (OUT_SHIFT>0 ? 2^(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT, i.e. round half up.
- dout <= r saturated to DOUT_WIDTH signed.
- out_sat <= (saturation occurred) || ovf-after-this-add.
- out_valid <= 1.
REQ-009 When en && !(v2 && last2), out_valid SHALL be 0 next cycle; dout and out_sat hold their values.
REQ-010 Latency: a last sample accepted in cycle T SHALL produce out_valid=1 in cycle T+3 with no stalls; throughput SHALL be one sample per cycle.
REQ-011 A sample with both in_first and in_last set SHALL produce round/sat(din0*din1) on its own.
REQ-012 A sample with neither flag set, arriving before any first, SHALL add to the current acc (0 after reset).
REQ-013 While out_valid=1 && out_ready=0, dout and out_sat SHALL be stable and in_ready SHALL be 0.

Reset
REQ-014 ap_rst=1 SHALL immediately force:
- v1, v2, out_valid, out_sat, ovf = 0;
- acc, p, dout = 0;
- in_ready = 1.
REQ-015 Reset mid-accumulation SHALL discard all in-flight samples; no result SHALL be emitted for them after release.

Verification
REQ-016 Defaults, single sample din0=100, din1=-3, first=last=1, out_ready=1 -> dout=-300, out_sat=0, 3 cycles after accept.
REQ-017 Defaults, back-to-back samples (8191,31)[first] then (-8192,31)[last] -> acc=-31; dout=-31, out_sat=0. Single sample (8191,31) first+last -> dout=32767, out_sat=1. Single sample (-8192,31) first+last -> dout=-32768, out_sat=1.
REQ-018 Accumulator overflow: 33 samples (-8192,-32), first on #1, last on #33 -> dout=32767, out_sat=1. The next first+last (1,1) -> dout=1, out_sat=0.
REQ-019 OUT_SHIFT=4: first+last (24,1) -> dout=2. First+last (-24,1) -> dout=-1.
REQ-020 Stall: hold out_ready=0 for 5 cycles while streaming -> in_ready=0, dout stable, no sample lost; after release, all results appear in order.
REQ-021 Reset: assert ap_rst with 3 samples in flight -> out_valid=0 immediately, no result after release. Then first+last (2,3) -> dout=6.

Source files
------------

// File: rtl/cnn_mac_pipe_dsp.sv
// ----------------------------------------------------------------------------
// cnn_mac_pipe_dsp
//
// Pipelined signed multiply-accumulate for CNN inner products. Samples are
// grouped into accumulations delimited by in_first / in_last. When the last
// sample of a group has been added, the accumulator is rounded (half up),
// shifted right by OUT_SHIFT and saturated to DOUT_WIDTH.
//
// Pipeline: stage 1 registers the operands, stage 2 registers the product,
// and stage 3 updates the accumulator and registers the result. The whole
// pipe advances on a single enable, so a stalled output freezes every stage.
//
// Ports:
//   ap_clk     clock, all state on its rising edge
//   ap_rst     asynchronous active-high reset
//   in_valid   input sample valid
//   in_ready   sample accepted this cycle (combinational from the output side)
//   din0       signed operand a, DIN0_WIDTH bits
//   din1       signed operand b, DIN1_WIDTH bits
//   in_first   sample starts a new accumulation
//   in_last    sample ends the accumulation and produces a result
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   dout       signed rounded and saturated result, DOUT_WIDTH bits
//   out_sat    result was clipped or the accumulator overflowed
// ----------------------------------------------------------------------------
module cnn_mac_pipe_dsp #(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 6,
    parameter int ACC_WIDTH  = 24,
    parameter int DOUT_WIDTH = 16,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_sat
);

    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
    // One guard bit so adding the rounding constant can never wrap.
    localparam int RND_WIDTH  = ACC_WIDTH + 1;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
        ACC_WIDTH'((64'sd1 <<< (ACC_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
        ACC_WIDTH'(-(64'sd1 <<< (ACC_WIDTH - 1)));
    localparam logic signed [RND_WIDTH-1:0] DOUT_MAX_X =
        RND_WIDTH'((64'sd1 <<< (DOUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [RND_WIDTH-1:0] DOUT_MIN_X =
        RND_WIDTH'(-(64'sd1 <<< (DOUT_WIDTH - 1)));
    // Half an output LSB; evaluates to zero when OUT_SHIFT is zero.
    localparam logic signed [RND_WIDTH-1:0] RND_CONST =
        RND_WIDTH'((64'sd1 <<< OUT_SHIFT) >>> 1);

    // Stage 1
    logic signed [DIN0_WIDTH-1:0] din0_q, din0_d;
    logic signed [DIN1_WIDTH-1:0] din1_q, din1_d;
    logic                         v1_q, v1_d;
    logic                         first1_q, first1_d;
    logic                         last1_q, last1_d;
    // Stage 2
    logic signed [PROD_WIDTH-1:0] p_q, p_d;
    logic                         v2_q, v2_d;
    logic                         first2_q, first2_d;
    logic                         last2_q, last2_d;
    // Stage 3 / output
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         ovf_q, ovf_d;
    logic                         out_valid_q, out_valid_d;
    logic [DOUT_WIDTH-1:0]        dout_q, dout_d;
    logic                         out_sat_q, out_sat_d;

    // Datapath intermediates
    logic                         en;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  p_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic                         add_ovf;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic                         ovf_next;
    logic signed [RND_WIDTH-1:0]  rnd_sum;
    logic signed [RND_WIDTH-1:0]  rounded;
    logic [DOUT_WIDTH-1:0]        dout_clamped;
    logic                         clamp_hit;

    // A held result freezes the entire pipe, input side included.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        prod    = PROD_WIDTH'(din0_q) * PROD_WIDTH'(din1_q);
        p_ext   = ACC_WIDTH'(p_q);
        sum     = acc_q + p_ext;
        // Signed overflow: operands agree in sign but the sum does not.
        add_ovf = (acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                  (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

        if (first2_q) begin
            // A fresh product always fits, and it restarts the sticky flag.
            acc_next = p_ext;
            ovf_next = 1'b0;
        end else if (add_ovf) begin
            acc_next = acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
            ovf_next = 1'b1;
        end else begin
            acc_next = sum;
            ovf_next = ovf_q;
        end

        rnd_sum = RND_WIDTH'(acc_next) + RND_CONST;
        rounded = rnd_sum >>> OUT_SHIFT;

        if (rounded > DOUT_MAX_X) begin
            dout_clamped = DOUT_WIDTH'(DOUT_MAX_X);
            clamp_hit    = 1'b1;
        end else if (rounded < DOUT_MIN_X) begin
            dout_clamped = DOUT_WIDTH'(DOUT_MIN_X);
            clamp_hit    = 1'b1;
        end else begin
            dout_clamped = DOUT_WIDTH'(rounded);
            clamp_hit    = 1'b0;
        end

        din0_d      = din0_q;
        din1_d      = din1_q;
        v1_d        = v1_q;
        first1_d    = first1_q;
        last1_d     = last1_q;
        p_d         = p_q;
        v2_d        = v2_q;
        first2_d    = first2_q;
        last2_d     = last2_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        out_sat_d   = out_sat_q;

        if (en) begin
            din0_d   = din0;
            din1_d   = din1;
            v1_d     = in_valid;
            first1_d = in_first;
            last1_d  = in_last;

            p_d      = prod;
            v2_d     = v1_q;
            first2_d = first1_q;
            last2_d  = last1_q;

            // Bubbles leave the accumulation untouched.
            if (v2_q) begin
                acc_d = acc_next;
                ovf_d = ovf_next;
            end

            if (v2_q && last2_q) begin
                out_valid_d = 1'b1;
                dout_d      = dout_clamped;
                out_sat_d   = clamp_hit || ovf_next;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: every flop, data included, is reset so no stale operand or sum survives a reset.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            din0_q      <= '0;
            din1_q      <= '0;
            v1_q        <= 1'b0;
            first1_q    <= 1'b0;
            last1_q     <= 1'b0;
            p_q         <= '0;
            v2_q        <= 1'b0;
            first2_q    <= 1'b0;
            last2_q     <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all stages update from pre-edge values.
            din0_q      <= din0_d;
            din1_q      <= din1_d;
            v1_q        <= v1_d;
            first1_q    <= first1_d;
            last1_q     <= last1_d;
            p_q         <= p_d;
            v2_q        <= v2_d;
            first2_q    <= first2_d;
            last2_q     <= last2_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_cnn_mac_pipe_dsp.sv
// ----------------------------------------------------------------------------
// tb_cnn_mac_pipe_dsp
//
// Two instances share one input stream: dut0 with default parameters and
// dut1 with OUT_SHIFT=4. Accepted samples feed a plain-arithmetic reference
// model that pushes the expected result of each finished accumulation into a
// per-instance queue; a negedge monitor pops and compares whenever a result
// is handed downstream, and checks output stability while it is held.
// ----------------------------------------------------------------------------
module tb_cnn_mac_pipe_dsp;

    localparam int W0 = 14;
    localparam int W1 = 6;
    localparam int WA = 24;
    localparam int WD = 16;

    localparam longint ACC_MAX  = (longint'(1) <<< (WA - 1)) - 1;
    localparam longint ACC_MIN  = -(longint'(1) <<< (WA - 1));
    localparam longint DOUT_MAX = (longint'(1) <<< (WD - 1)) - 1;
    localparam longint DOUT_MIN = -(longint'(1) <<< (WD - 1));

    typedef struct {
        longint d;
        bit     s;
    } exp_t;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b0;
    logic in_valid = 1'b0;
    logic in_first = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b1;
    logic [W0-1:0] din0 = '0;
    logic [W1-1:0] din1 = '0;

    logic in_ready0, in_ready1, out_valid0, out_valid1, out_sat0, out_sat1;
    logic signed [WD-1:0] dout0, dout1;

    exp_t   q0[$];
    exp_t   q1[$];
    exp_t   e0, e1;
    longint m_acc = 0;
    bit     m_ovf = 1'b0;
    longint m_prod;

    int n_vec = 0;
    int n_fail = 0;
    int n_chk = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

    longint last_d0 = 0, last_d1 = 0;
    bit     last_s0 = 0, last_s1 = 0;
    bit     held0 = 0, held1 = 0;
    longint hd0 = 0, hd1 = 0;
    bit     hs0 = 0, hs1 = 0;

    cnn_mac_pipe_dsp dut0 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready),
        .dout(dout0), .out_sat(out_sat0)
    );

    cnn_mac_pipe_dsp #(.OUT_SHIFT(4)) dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_valid(in_valid), .in_ready(in_ready1),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready),
        .dout(dout1), .out_sat(out_sat1)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Round half up at the given shift, then clip to the output range.
    function automatic exp_t make_exp(input longint acc, input bit ovf, input int sh);
        exp_t   e;
        longint r;
        r   = (acc + ((longint'(1) << sh) >>> 1)) >>> sh;
        e.s = ovf;
        if (r > DOUT_MAX) begin
            r   = DOUT_MAX;
            e.s = 1'b1;
        end else if (r < DOUT_MIN) begin
            r   = DOUT_MIN;
            e.s = 1'b1;
        end
        e.d = r;
        return e;
    endfunction

    // Reference model, scoreboard and monitor, all sampled away from the edge.
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            q0.delete();
            q1.delete();
            m_acc = 0;
            m_ovf = 1'b0;
            held0 = 1'b0;
            held1 = 1'b0;
        end else begin
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL dut0_unexpected: got dout %0d, expected no result", dout0);
                end else begin
                    e0 = q0.pop_front();
                    check("dut0_dout", longint'(dout0), e0.d);
                    check("dut0_sat", longint'(out_sat0), longint'(e0.s));
                    last_d0 = longint'(dout0);
                    last_s0 = out_sat0;
                end
                held0 = 1'b0;
            end else if (out_valid0) begin
                if (held0) begin
                    check("dut0_hold_dout", longint'(dout0), hd0);
                    check("dut0_hold_sat", longint'(out_sat0), longint'(hs0));
                end
                check("dut0_in_ready_stalled", longint'(in_ready0), 0);
                held0 = 1'b1;
                hd0   = longint'(dout0);
                hs0   = out_sat0;
            end

            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL dut1_unexpected: got dout %0d, expected no result", dout1);
                end else begin
                    e1 = q1.pop_front();
                    check("dut1_dout", longint'(dout1), e1.d);
                    check("dut1_sat", longint'(out_sat1), longint'(e1.s));
                    last_d1 = longint'(dout1);
                    last_s1 = out_sat1;
                end
                held1 = 1'b0;
            end else if (out_valid1) begin
                if (held1) begin
                    check("dut1_hold_dout", longint'(dout1), hd1);
                    check("dut1_hold_sat", longint'(out_sat1), longint'(hs1));
                end
                held1 = 1'b1;
                hd1   = longint'(dout1);
                hs1   = out_sat1;
            end

            if (in_valid && in_ready0) begin
                n_vec++;
                m_prod = longint'(signed'(din0)) * longint'(signed'(din1));
                if (in_first) begin
                    m_acc = m_prod;
                    m_ovf = 1'b0;
                end else begin
                    m_acc = m_acc + m_prod;
                    if (m_acc > ACC_MAX) begin
                        m_acc = ACC_MAX;
                        m_ovf = 1'b1;
                    end else if (m_acc < ACC_MIN) begin
                        m_acc = ACC_MIN;
                        m_ovf = 1'b1;
                    end
                end
                if (in_last) begin
                    q0.push_back(make_exp(m_acc, m_ovf, 0));
                    q1.push_back(make_exp(m_acc, m_ovf, 4));
                end
            end
        end
    end

    // Downstream readiness pattern.
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input longint a, input longint b, input bit f, input bit l);
        int w;
        din0     = W0'(a);
        din1     = W1'(b);
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        w = 0;
        @(negedge ap_clk);
        while (!in_ready0) begin
            if (w >= 200) begin
                n_fail++;
                $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected acceptance", w);
                break;
            end
            @(negedge ap_clk);
            w++;
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 100) begin
            @(negedge ap_clk);
            w++;
        end
        check("drain_pending", longint'(q0.size() + q1.size()), 0);
        idle(1);
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        int k;

        // Reset state.
        #1 ap_rst = 1'b1;
        #2;
        check("rst_out_valid", longint'(out_valid0), 0);
        check("rst_in_ready", longint'(in_ready0), 1);
        check("rst_dout", longint'(dout0), 0);
        check("rst_out_sat", longint'(out_sat0), 0);
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        idle(1);

        // Single sample, including latency to out_valid.
        send(100, -3, 1, 1);
        k = 0;
        while (!out_valid0 && k < 10) begin
            @(negedge ap_clk);
            k++;
        end
        check("latency_cycles", longint'(k), 3);
        drain();
        check("single_dout", last_d0, -300);
        check("single_sat", longint'(last_s0), 0);

        // Back-to-back pair and single-sample saturation.
        send(8191, 31, 1, 0);
        send(-8192, 31, 0, 1);
        drain();
        check("pair_dout", last_d0, -31);
        check("pair_sat", longint'(last_s0), 0);
        send(8191, 31, 1, 1);
        drain();
        check("pos_clip_dout", last_d0, 32767);
        check("pos_clip_sat", longint'(last_s0), 1);
        send(-8192, 31, 1, 1);
        drain();
        check("neg_clip_dout", last_d0, -32768);
        check("neg_clip_sat", longint'(last_s0), 1);

        // Accumulator overflow, then recovery on a fresh first.
        for (int i = 1; i <= 33; i++) send(-8192, -32, i == 1, i == 33);
        drain();
        check("acc_ovf_dout", last_d0, 32767);
        check("acc_ovf_sat", longint'(last_s0), 1);
        send(1, 1, 1, 1);
        drain();
        check("after_ovf_dout", last_d0, 1);
        check("after_ovf_sat", longint'(last_s0), 0);

        // Rounding on the shifted instance.
        send(24, 1, 1, 1);
        drain();
        check("shift4_pos_dout", last_d1, 2);
        send(-24, 1, 1, 1);
        drain();
        check("shift4_neg_dout", last_d1, -1);

        // Stall: results held while the stream keeps offering samples.
        ready_mode = 2;
        idle(1);
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(int'($urandom_range(0, 16383)) - 8192,
                         int'($urandom_range(0, 63)) - 32, 1, 1);
            end
            begin
                repeat (8) @(negedge ap_clk);
                check("stall_in_ready", longint'(in_ready0), 0);
                check("stall_out_valid", longint'(out_valid0), 1);
                ready_mode = 0;
            end
        join
        drain();

        // Randomized stream with random backpressure.
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            longint a, b;
            int     sel;
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      a = 8191;
            else if (sel == 1) a = -8192;
            else               a = longint'(int'($urandom_range(0, 16383)) - 8192);
            if (sel < 2) b = ($urandom_range(0, 1) != 0) ? 31 : -32;
            else         b = longint'(int'($urandom_range(0, 63)) - 32);
            send(a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end
        ready_mode = 0;
        idle(1);
        drain();

        // Reset with a result pending and samples in flight.
        send(9, 9, 1, 1);
        send(1, 2, 1, 0);
        send(3, 4, 0, 1);
        ap_rst = 1'b1;
        #1;
        check("midrst_out_valid0", longint'(out_valid0), 0);
        check("midrst_out_valid1", longint'(out_valid1), 0);
        check("midrst_in_ready", longint'(in_ready0), 1);
        check("midrst_dout", longint'(dout0), 0);
        check("midrst_out_sat", longint'(out_sat0), 0);
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        idle(10);

        // Accumulation without a first starts from zero after reset.
        send(5, 7, 0, 0);
        send(1, 1, 0, 1);
        drain();
        check("no_first_dout", last_d0, 36);
        send(2, 3, 1, 1);
        drain();
        check("post_rst_dout", last_d0, 6);
        check("post_rst_sat", longint'(last_s0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
